// File: rtl/bit_scheduler.sv
// Splits an 8-bit operand mask into a stream of MSB-first leading-one index beats,
// emitting up to MAX_EMIT beats per operand with a ready/valid handshake on each side.
module bit_scheduler #(
   parameter int MAX_EMIT = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_mask,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [2:0] out_idx,
   output logic       out_last,
   output logic       out_zero,
   output logic [3:0] out_cnt,
   output logic       busy
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [3:0] LAST_CNT = 4'(MAX_EMIT - 1);

   state_t     state_q;
   logic [7:0] rem_q;
   logic [3:0] cnt_q;
   logic       zero_q;
   logic       single_bit;
   logic       out_xfer;
   logic       in_xfer;

   // Ascending scan so the highest set bit wins; index counts from bit 7.
   function automatic logic [2:0] lead_idx(input logic [7:0] m);
      lead_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (m[i]) lead_idx = 3'(7 - i);
      end
   endfunction

   assign out_idx    = lead_idx(rem_q);
   assign single_bit = (rem_q != 8'd0) && ((rem_q & (rem_q - 8'd1)) == 8'd0);
   assign out_last   = single_bit || (cnt_q == LAST_CNT) || zero_q;
   assign out_zero   = zero_q;
   assign out_cnt    = cnt_q;
   assign out_valid  = (state_q == BUSY);
   assign busy       = (state_q == BUSY);
   assign out_xfer   = out_valid && out_ready;
   assign in_ready   = !out_valid || (out_ready && out_last);
   assign in_xfer    = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rem_q   <= 8'd0;
         cnt_q   <= 4'd0;
         zero_q  <= 1'b0;
      end else if (in_xfer) begin
         // Covers both an idle load and a back-to-back reload on the last beat.
         state_q <= BUSY;
         rem_q   <= in_mask;
         cnt_q   <= 4'd0;
         zero_q  <= (in_mask == 8'd0);
      end else if (out_xfer) begin
         if (out_last) begin
            state_q <= IDLE;
            rem_q   <= 8'd0;
         end else begin
            rem_q <= rem_q & ~(8'h80 >> out_idx);
            cnt_q <= cnt_q + 4'd1;
         end
      end
   end

endmodule
